// File: rtl/path_lifo_fifo.sv
// Path buffer for the route solver: explores as a LIFO stack, then replays the
// surviving entries bottom-to-top as a FIFO once replay_start is pulsed.
module path_lifo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              replay_start,
    input  logic              replay_en,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              mode,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic {STACK = 1'b0, REPLAY = 1'b1} modeT;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    modeT              modeQ, nextMode;
    logic [ADDR_W:0]   countQ, nextCount;
    logic [ADDR_W:0]   rdPtrQ, nextRdPtr;
    logic [DATA_W-1:0] dataOutQ;
    logic              outValidQ, overflowQ, underflowQ;

    logic              isEmpty, isFull;
    logic [ADDR_W-1:0] countLo, topAddr;
    logic              writeEn, readEn, setOverflow, setUnderflow;
    logic [ADDR_W-1:0] writeAddr, readAddr;

    assign isEmpty = (modeQ == STACK) ? (countQ == '0) : (rdPtrQ == countQ);
    assign isFull  = (countQ == DEPTH_C);
    assign countLo = countQ[ADDR_W-1:0];
    // When the stack is full countLo wraps to 0, so topAddr still lands on DEPTH-1.
    assign topAddr = countLo - ONE_A;

    always_comb begin
        nextMode     = modeQ;
        nextCount    = countQ;
        nextRdPtr    = rdPtrQ;
        writeEn      = 1'b0;
        writeAddr    = countLo;
        readEn       = 1'b0;
        readAddr     = topAddr;
        setOverflow  = 1'b0;
        setUnderflow = 1'b0;
        if (!clear) begin
            if (modeQ == STACK) begin
                if (replay_start) begin
                    nextMode  = REPLAY;
                    nextRdPtr = '0;
                end else if (push && pop) begin
                    writeEn = 1'b1;
                    if (!isEmpty) begin
                        writeAddr = topAddr;
                        readEn    = 1'b1;
                    end else begin
                        nextCount    = countQ + ONE_C;
                        setUnderflow = 1'b1;
                    end
                end else if (push) begin
                    if (!isFull) begin
                        writeEn   = 1'b1;
                        nextCount = countQ + ONE_C;
                    end else begin
                        setOverflow = 1'b1;
                    end
                end else if (pop) begin
                    if (!isEmpty) begin
                        readEn    = 1'b1;
                        nextCount = countQ - ONE_C;
                    end else begin
                        setUnderflow = 1'b1;
                    end
                end
            end else if (pop && replay_en) begin
                if (rdPtrQ < countQ) begin
                    readEn    = 1'b1;
                    readAddr  = rdPtrQ[ADDR_W-1:0];
                    nextRdPtr = rdPtrQ + ONE_C;
                end else begin
                    setUnderflow = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            modeQ      <= STACK;
            countQ     <= '0;
            rdPtrQ     <= '0;
            dataOutQ   <= '0;
            outValidQ  <= 1'b0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else if (clear) begin
            modeQ      <= STACK;
            countQ     <= '0;
            rdPtrQ     <= '0;
            dataOutQ   <= '0;
            outValidQ  <= 1'b0;
            overflowQ  <= 1'b0;
            underflowQ <= 1'b0;
        end else begin
            modeQ      <= nextMode;
            countQ     <= nextCount;
            rdPtrQ     <= nextRdPtr;
            outValidQ  <= readEn;
            overflowQ  <= overflowQ | setOverflow;
            underflowQ <= underflowQ | setUnderflow;
            if (readEn) dataOutQ <= mem[readAddr];
        end
    end

    // Storage is left uninitialised so it can map onto a plain RAM.
    always_ff @(posedge clk) begin
        if (writeEn) mem[writeAddr] <= data_in;
    end

    assign data_out  = dataOutQ;
    assign out_valid = outValidQ;
    assign mode      = (modeQ == REPLAY);
    assign empty     = isEmpty;
    assign full      = isFull;
    assign count     = countQ;
    assign overflow  = overflowQ;
    assign underflow = underflowQ;

endmodule

// File: tb/tb_path_lifo_fifo.sv
// Scoreboard bench for path_lifo_fifo (DEPTH=4): stimulus queues expected words,
// a negedge monitor checks every out_valid pulse against the queue.
module tb_path_lifo_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear, push, pop, replay_start, replay_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       out_valid, mode, empty, full, overflow, underflow;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ [$];

    path_lifo_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop),
        .data_in(data_in), .replay_start(replay_start), .replay_en(replay_en),
        .data_out(data_out), .out_valid(out_valid), .mode(mode), .empty(empty),
        .full(full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the edge with inputs idle.
    task automatic applyStimulus(input logic p, input logic po, input logic [7:0] d,
                                 input logic rs, input logic re, input logic cl);
        push = p; pop = po; data_in = d; replay_start = rs; replay_en = re; clear = cl;
        @(posedge clk); #1;
        push = 0; pop = 0; data_in = '0; replay_start = 0; replay_en = 0; clear = 0;
    endtask

    task automatic doPush(input logic [7:0] d);
        applyStimulus(1, 0, d, 0, 0, 0);
    endtask

    task automatic doPop(input logic [7:0] expected);
        expQ.push_back(expected);
        applyStimulus(0, 1, '0, 0, 0, 0);
    endtask

    task automatic doReplayPop(input logic [7:0] expected);
        expQ.push_back(expected);
        applyStimulus(0, 1, '0, 0, 1, 0);
    endtask

    task automatic doClear();
        applyStimulus(0, 0, '0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedValid: got out_valid=1 data 0x%0h, expected no output", data_out);
            end else begin
                checkOutput("dataOut", {24'd0, data_out}, {24'd0, expQ.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 0; clear = 0; push = 0; pop = 0; data_in = '0;
        replay_start = 0; replay_en = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetCount", 32'(count), 0);
        checkOutput("resetEmpty", 32'(empty), 1);
        checkOutput("resetValid", 32'(out_valid), 0);
        rst = 1;

        // Async reset in the middle of a push stream
        doPush(8'hA1);
        doPush(8'hA2);
        doPop(8'hA2);
        applyStimulus(0, 0, '0, 0, 0, 0);
        checkOutput("preResetData", 32'(data_out), 32'hA2);
        push = 1; data_in = 8'hA3;
        #2 rst = 0;
        #1;
        checkOutput("asyncCount", 32'(count), 0);
        checkOutput("asyncEmpty", 32'(empty), 1);
        checkOutput("asyncMode", 32'(mode), 0);
        checkOutput("asyncData", 32'(data_out), 0);
        push = 0; data_in = '0;
        #3 rst = 1;
        @(posedge clk); #1;

        // LIFO order
        doPush(8'h11);
        doPush(8'h22);
        doPush(8'h33);
        checkOutput("stackCount3", 32'(count), 3);
        doPop(8'h33);
        doPop(8'h22);
        checkOutput("stackCount1", 32'(count), 1);
        checkOutput("stackData", 32'(data_out), 32'h22);
        doClear();
        checkOutput("clearCount", 32'(count), 0);

        // Full / overflow, then underflow on empty pop
        for (int i = 1; i <= 5; i++) begin
            doPush(8'(i));
            if (i == 3) checkOutput("notFull3", 32'(full), 0);
            if (i == 4) checkOutput("full4", 32'(full), 1);
        end
        checkOutput("ovfCount", 32'(count), 4);
        checkOutput("ovfFlag", 32'(overflow), 1);
        doPop(8'h04);
        checkOutput("afterFullPop", 32'(count), 3);
        doClear();
        checkOutput("clrOverflow", 32'(overflow), 0);
        checkOutput("clrFull", 32'(full), 0);
        checkOutput("clrEmpty", 32'(empty), 1);
        applyStimulus(0, 1, '0, 0, 0, 0);
        checkOutput("emptyPopUnf", 32'(underflow), 1);
        checkOutput("emptyPopCnt", 32'(count), 0);
        doClear();
        checkOutput("clrUnderflow", 32'(underflow), 0);

        // Replay bottom-to-top, then overrun
        doPush(8'h11);
        doPush(8'h22);
        doPush(8'h33);
        doPop(8'h33);
        applyStimulus(1, 0, 8'hEE, 1, 0, 0);
        checkOutput("replayMode", 32'(mode), 1);
        checkOutput("replayCount", 32'(count), 2);
        checkOutput("replayEmpty0", 32'(empty), 0);
        doReplayPop(8'h11);
        doReplayPop(8'h22);
        checkOutput("replayUnf0", 32'(underflow), 0);
        applyStimulus(0, 1, '0, 0, 1, 0);
        checkOutput("replayUnf1", 32'(underflow), 1);
        checkOutput("replayEmpty1", 32'(empty), 1);
        checkOutput("replayMode1", 32'(mode), 1);
        doClear();
        checkOutput("clrMode", 32'(mode), 0);

        // Simultaneous push and pop replaces the top
        doPush(8'h11);
        doPush(8'h22);
        expQ.push_back(8'h22);
        applyStimulus(1, 1, 8'h44, 0, 0, 0);
        checkOutput("replaceCount", 32'(count), 2);
        doPop(8'h44);
        doPop(8'h11);
        checkOutput("replaceDrain", 32'(count), 0);
        applyStimulus(1, 1, 8'h55, 0, 0, 0);
        checkOutput("emptyPPCount", 32'(count), 1);
        checkOutput("emptyPPUnf", 32'(underflow), 1);
        doPop(8'h55);
        doClear();

        // REPLAY ignores push and ungated pop; replay_start does not restart
        doPush(8'h11);
        doPush(8'h22);
        applyStimulus(0, 0, '0, 1, 0, 0);
        applyStimulus(1, 1, 8'h99, 0, 0, 0);
        checkOutput("gatedCount", 32'(count), 2);
        checkOutput("gatedEmpty", 32'(empty), 0);
        checkOutput("gatedUnf", 32'(underflow), 0);
        checkOutput("gatedOvf", 32'(overflow), 0);
        doReplayPop(8'h11);
        applyStimulus(0, 0, '0, 1, 0, 0);
        checkOutput("noRestartMode", 32'(mode), 1);
        doReplayPop(8'h22);
        checkOutput("holdData", 32'(data_out), 32'h22);

        repeat (3) applyStimulus(0, 0, '0, 0, 0, 0);
        checkOutput("pendingOutputs", 32'(expQ.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
